level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
// - Gameplay engine driven by game_states: consumes current_state/current_level, produces level_complete and game_over_signal.
// - On entry to LEVEL_INCREMENT (2'b01):
//   - shows a pseudo-random pattern of current_level+1 steps on led[3:0];
//   - then checks the player's switch presses against that pattern.
// - Sits between the switch inputs, the LED drivers and game_states.
// PARAMETERS
// - SHOW_CYCLES  25_000_000  clocks a step's LED is lit
// - GAP_CYCLES   12_500_000  clocks dark between steps
// - MAX_LEN      16          pattern buffer depth (>=9); entries are 2-bit switch indices
// - SEED         16'hACE1    LFSR reset value (must be non-zero)
// - TIMEOUT_CYCLES 250_000_000  input-phase idle limit (used only with LEVEL_SEQ_TIMEOUT_EN)
// PORTS
// - clk               in   1  system clock
// - reset             in   1  synchronous, active-high
// - current_state     in   2  from game_states; 2'b01 = LEVEL_INCREMENT
// - current_level     in   4  from game_states; 0..8
// - switch1..switch4  in   1 each  debounced, active-high player buttons
// - led               out  4  one-hot pattern display; bit n = switch(n+1)
// - level_complete    out  1  1-cycle pulse: whole pattern entered correctly
// - game_over_signal  out  1  1-cycle pulse: wrong press (or timeout)
// - busy              out  1  high from GEN through CHECK inclusive
// BEHAVIOUR
// - Reset (sync, dominant):
//   - led=0, pulses=0, busy=0, FSM=IDLE;
//   - LFSR=SEED, buffer contents don't-care.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
//   Player timing therefore varies the pattern.
// - len = min(current_level,MAX_LEN-1)+1; step index idx is 4 bits.
// - FSM:
//   - IDLE: current_state==01 -> GEN if current_level==0, else SHOW_ON with idx=0.
//   - GEN: one buffer entry per cycle, buf[i]=lfsr[1:0], for i=0..MAX_LEN-1; then SHOW_ON, idx=0.
//     The pattern is fixed for the whole game; each level replays the prefix, one step longer.
//   - SHOW_ON: led = 1<<buf[idx] for SHOW_CYCLES clocks -> SHOW_OFF.
//   - SHOW_OFF: led=0 for GAP_CYCLES clocks.
//     - idx+1<len -> SHOW_ON, idx++;
//     - otherwise -> CHECK, idx=0.
//   - CHECK: sw_q = registered switches; rise = sw & ~sw_q.
//     - rise==0: stay.
//     - rise one-hot and equal to 1<<buf[idx]: correct.
//       - idx+1==len -> pulse level_complete, go DONE;
//       - else idx++.
//     - rise one-hot but wrong, or more than one bit set: pulse game_over_signal, go DONE.
//   - DONE: outputs idle; -> IDLE once current_state!=01 (prevents retrigger).
// - Pulse timing: asserted exactly one cycle, in the cycle after the deciding rise is sampled.
// - Feedback: led mirrors held switches (led = sw) during CHECK.
// - Abort: current_state!=01 while in GEN/SHOW_ON/SHOW_OFF/CHECK (e.g. all-four-switch chord) -> IDLE next cycle.
//   led=0, no pulse; buffer kept unless the next level is 0.
// - Switch edges outside CHECK are ignored.
//   sw_q is sampled continuously, so a button held into CHECK does not count as a press.
// - Simultaneous rise on two switches = wrong press.
// CONFIGURATION
// - LEVEL_SEQ_TIMEOUT_EN defined:
//   - CHECK counts clocks since entry or since the last accepted press;
//   - reaching TIMEOUT_CYCLES -> game_over_signal pulse, go DONE.
// - Undefined: no counter; CHECK waits indefinitely.
// TESTING (SHOW_CYCLES=4, GAP_CYCLES=2, MAX_LEN=16, TIMEOUT_CYCLES=20)
// - reset mid-SHOW_ON -> next cycle led=0, busy=0, FSM IDLE, no pulse.
// - level 0, state=01 -> 16 GEN cycles, then led = 1<<buf[0] for 4 cycles, 0 for 2; press matching switch -> level_complete high 1 cycle.
// - level 2 -> exactly 3 lit steps (18 cycles); correct, correct, wrong press -> game_over_signal 1 cycle, no level_complete.
// - switch1+switch3 rise same cycle in CHECK -> game_over_signal.
// - current_state forced 00 during CHECK -> IDLE, no pulses; state back to 01 -> replay from idx 0.
// - LEVEL_SEQ_TIMEOUT_EN, no press 20 cycles in CHECK -> game_over_signal; undefined -> no pulse after 100 cycles.

Source files
------------

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//
// Purpose:
//   Gameplay engine that runs one level of a memory game. When game_states
//   enters LEVEL_INCREMENT (current_state == 2'b01) it shows a pseudo-random
//   pattern of current_level+1 steps on the LEDs, then checks the player's
//   button presses against that pattern and reports the result with a
//   one-cycle level_complete or game_over_signal pulse.
//
//   The pattern buffer is filled only when a game starts (level 0) and is then
//   replayed as a growing prefix on every following level.
//
// Optional feature:
//   LEVEL_SEQ_TIMEOUT_EN - when defined, the input phase ends with a
//   game_over_signal pulse after TIMEOUT_CYCLES clocks without an accepted
//   press. When undefined, the input phase waits indefinitely.
//
// Ports:
//   clk               in   1  system clock
//   reset             in   1  synchronous, active-high, dominant
//   current_state     in   2  from game_states; 2'b01 = LEVEL_INCREMENT
//   current_level     in   4  from game_states; 0..8
//   switch1..switch4  in   1  debounced, active-high player buttons
//   led               out  4  one-hot pattern display; bit n = switch(n+1)
//   level_complete    out  1  1-cycle pulse: whole pattern entered correctly
//   game_over_signal  out  1  1-cycle pulse: wrong press (or timeout)
//   busy              out  1  high from GEN through CHECK inclusive
//
// States:
//   IDLE     | waiting for current_state == LEVEL_INCREMENT
//   GEN      | filling the pattern buffer from the LFSR, one entry per cycle
//   SHOW_ON  | LED for step idx lit for SHOW_CYCLES clocks
//   SHOW_OFF | LEDs dark for GAP_CYCLES clocks between steps
//   CHECK    | comparing switch rising edges against the pattern
//   DONE     | result reported; wait for current_state to leave 2'b01
// -----------------------------------------------------------------------------
module level_sequencer #(
  parameter int unsigned SHOW_CYCLES    = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic [3:0] current_level,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic [3:0] led,
  output logic       level_complete,
  output logic       game_over_signal,
  output logic       busy
);

  // Parameter sanity: the step index is 4 bits and entries are replayed from
  // index 0, so the buffer must hold the longest level (9 steps) and fit idx.
  if (MAX_LEN < 9 || MAX_LEN > 16) begin : g_bad_max_len
    $error("level_sequencer: MAX_LEN must be in 9..16");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("level_sequencer: SEED must be non-zero");
  end
  if (SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_timing
    $error("level_sequencer: cycle counts out of range");
  end

  localparam int unsigned TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  // Timer holds at most TMR_MAX-1 (down-counter with terminal count at zero).
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [1:0]       r_buf [MAX_LEN];
  logic [3:0]       r_idx;
  logic [4:0]       r_len;
  logic [TMR_W-1:0] r_tmr;
  logic [3:0]       r_sw_q;
  logic [3:0]       r_led;
  logic             r_lc;
  logic             r_go;
  logic             r_busy;

  logic             w_lfsr_fb;
  logic [3:0]       w_sw;
  logic [3:0]       w_rise;
  logic             w_active;
  logic [3:0]       w_lvl_clip;
  logic [4:0]       w_len;
  logic             w_last;
  logic [3:0]       w_first_mask;
  logic [3:0]       w_cur_mask;
  logic [3:0]       w_next_mask;
  logic             w_timeout;

  // Fibonacci taps 16,14,13,11 (bit numbers 1..16 map to indices 0..15).
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_sw     = {switch4, switch3, switch2, switch1};
  assign w_rise   = w_sw & ~r_sw_q;
  assign w_active = (current_state == 2'b01);

  assign w_lvl_clip = (current_level > LAST_IDX) ? LAST_IDX : current_level;
  assign w_len      = {1'b0, w_lvl_clip} + 5'd1;
  assign w_last     = (({1'b0, r_idx} + 5'd1) == r_len);

  assign w_first_mask = 4'b0001 << r_buf[0];
  assign w_cur_mask   = 4'b0001 << r_buf[r_idx];
  // Only consulted while idx+1 < len, so the 4-bit wrap of idx+1 never matters.
  assign w_next_mask  = 4'b0001 << r_buf[r_idx + 4'd1];

`ifdef LEVEL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;
  assign w_timeout = (r_to_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  // LFSR free-runs so that the moment the player starts a game picks the
  // pattern. Switch history is sampled every cycle so that a button already
  // held when CHECK begins is not mistaken for a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
      r_sw_q <= 4'b0000;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_sw_q <= w_sw;
    end
  end

  // Pattern storage has no reset; contents are only meaningful after GEN.
  always_ff @(posedge clk) begin
    if (r_state == S_GEN) begin
      r_buf[r_idx] <= r_lfsr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_len    <= 5'd1;
      r_tmr    <= '0;
      r_led    <= 4'b0000;
      r_lc     <= 1'b0;
      r_go     <= 1'b0;
      r_busy   <= 1'b0;
`ifdef LEVEL_SEQ_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      r_lc <= 1'b0;
      r_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_led  <= 4'b0000;
          r_busy <= 1'b0;
          r_idx  <= 4'd0;
          if (w_active) begin
            r_len  <= w_len;
            r_busy <= 1'b1;
            if (current_level == 4'd0) begin
              r_state <= S_GEN;
            end else begin
              r_state <= S_SHOW_ON;
              r_led   <= w_first_mask;
              r_tmr   <= SHOW_LOAD;
            end
          end
        end

        S_GEN: begin
          if (!w_active) begin
            r_state <= S_IDLE;
            r_led   <= 4'b0000;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
          end else if (r_idx == LAST_IDX) begin
            // buf[0] was written on the first GEN cycle, so it is safe to show.
            r_state <= S_SHOW_ON;
            r_idx   <= 4'd0;
            r_led   <= w_first_mask;
            r_tmr   <= SHOW_LOAD;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end

        S_SHOW_ON: begin
          if (!w_active) begin
            r_state <= S_IDLE;
            r_led   <= 4'b0000;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
          end else if (r_tmr == '0) begin
            r_state <= S_SHOW_OFF;
            r_led   <= 4'b0000;
            r_tmr   <= GAP_LOAD;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        S_SHOW_OFF: begin
          if (!w_active) begin
            r_state <= S_IDLE;
            r_led   <= 4'b0000;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
          end else if (r_tmr == '0) begin
            if (!w_last) begin
              r_state <= S_SHOW_ON;
              r_idx   <= r_idx + 4'd1;
              r_led   <= w_next_mask;
              r_tmr   <= SHOW_LOAD;
            end else begin
              r_state  <= S_CHECK;
              r_idx    <= 4'd0;
              r_led    <= w_sw;
`ifdef LEVEL_SEQ_TIMEOUT_EN
              r_to_cnt <= TO_LOAD;
`endif
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        S_CHECK: begin
          if (!w_active) begin
            r_state <= S_IDLE;
            r_led   <= 4'b0000;
            r_busy  <= 1'b0;
            r_idx   <= 4'd0;
          end else begin
            r_led <= w_sw;
            if (w_rise != 4'b0000) begin
              // The expected mask is one-hot, so equality also rejects chords.
              if (w_rise == w_cur_mask) begin
                if (w_last) begin
                  r_lc    <= 1'b1;
                  r_state <= S_DONE;
                  r_led   <= 4'b0000;
                  r_busy  <= 1'b0;
                end else begin
                  r_idx    <= r_idx + 4'd1;
`ifdef LEVEL_SEQ_TIMEOUT_EN
                  r_to_cnt <= TO_LOAD;
`endif
                end
              end else begin
                r_go    <= 1'b1;
                r_state <= S_DONE;
                r_led   <= 4'b0000;
                r_busy  <= 1'b0;
              end
            end else if (w_timeout) begin
              r_go    <= 1'b1;
              r_state <= S_DONE;
              r_led   <= 4'b0000;
              r_busy  <= 1'b0;
            end else begin
`ifdef LEVEL_SEQ_TIMEOUT_EN
              r_to_cnt <= r_to_cnt - 1'b1;
`endif
            end
          end
        end

        S_DONE: begin
          r_led  <= 4'b0000;
          r_busy <= 1'b0;
          r_idx  <= 4'd0;
          // Holding here until game_states moves on prevents a retrigger.
          if (!w_active) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_led   <= 4'b0000;
          r_busy  <= 1'b0;
          r_idx   <= 4'd0;
        end
      endcase
    end
  end

  assign led              = r_led;
  assign level_complete   = r_lc;
  assign game_over_signal = r_go;
  assign busy             = r_busy;

endmodule

// File: tb/tb_level_sequencer.sv
module tb_level_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MODE_OK    = 0;
  localparam int MODE_WRONG = 1;
  localparam int MODE_CHORD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] current_state;
  logic [3:0] current_level;
  logic       switch1, switch2, switch3, switch4;
  logic [3:0] led;
  logic       level_complete;
  logic       game_over_signal;
  logic       busy;

  always #5 clk = ~clk;

  level_sequencer #(
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2),
    .MAX_LEN(16),
    .SEED(SEED),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .current_state(current_state),
    .current_level(current_level),
    .switch1(switch1),
    .switch2(switch2),
    .switch3(switch3),
    .switch4(switch4),
    .led(led),
    .level_complete(level_complete),
    .game_over_signal(game_over_signal),
    .busy(busy)
  );

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every clock.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of expected pulses: kind = {level_complete, game_over_signal}.
  typedef struct {
    logic [1:0] kind;
    int         at;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [3:0] lvl;
    int         n_ok;
    int         mode;
    logic [1:0] exp_pulse;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_buf [16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    if (level_complete || game_over_signal) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'({level_complete, game_over_signal}), 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", int'({level_complete, game_over_signal}), int'(e.kind));
        check("pulse_cycle", cyc, e.at);
      end
    end else if (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check("missing_pulse", 0, int'(e.kind));
    end
  endtask

  function automatic logic [3:0] mask_of(input logic [1:0] b);
    logic [3:0] m;
    m = 4'b0001 << b;
    return m;
  endfunction

  task automatic set_sw(input logic [3:0] m);
    {switch4, switch3, switch2, switch1} = m;
  endtask

  task automatic press(input logic [3:0] m, input logic [1:0] kind);
    set_sw(m);
    if (kind != 2'b00) sb.push_back('{kind: kind, at: cyc + 1});
    step();
    if (kind == 2'b00) begin
      check("led_mirror", int'(led), int'(m));
    end else begin
      check("done_busy", int'(busy), 0);
      check("done_led", int'(led), 0);
    end
    set_sw(4'b0000);
    step();
  endtask

  task automatic go_idle();
    current_state = 2'b00;
    step();
    step();
    check("idle_busy", int'(busy), 0);
    check("idle_led", int'(led), 0);
  endtask

  // Starts a level and follows the display phase cycle by cycle, ending on
  // the first sample taken in CHECK.
  task automatic run_show(input logic [3:0] lvl);
    int         len;
    int         lit;
    logic [3:0] prev;
    current_level = lvl;
    current_state = 2'b01;
    len = int'(lvl) + 1;
    if (lvl == 4'd0) begin
      for (int i = 0; i < 16; i++) begin
        step();
        exp_buf[i] = m_lfsr[1:0];
        check("gen_busy", int'(busy), 1);
        check("gen_led", int'(led), 0);
      end
    end
    lit  = 0;
    prev = 4'b0000;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check("show_led", int'(led), int'(mask_of(exp_buf[k])));
        if (led != 4'b0000 && prev == 4'b0000) lit++;
        prev = led;
      end
      check("show_busy", int'(busy), 1);
      for (int c = 0; c < 2; c++) begin
        step();
        check("gap_led", int'(led), 0);
        prev = led;
      end
    end
    check("lit_steps", lit, len);
    step();
    check("check_busy", int'(busy), 1);
    check("check_led", int'(led), 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{lvl: 4'd0, n_ok: 1, mode: MODE_OK,    exp_pulse: 2'b10};
    vecs[1] = '{lvl: 4'd2, n_ok: 2, mode: MODE_WRONG, exp_pulse: 2'b01};
    vecs[2] = '{lvl: 4'd1, n_ok: 2, mode: MODE_OK,    exp_pulse: 2'b10};
    vecs[3] = '{lvl: 4'd3, n_ok: 1, mode: MODE_CHORD, exp_pulse: 2'b01};
    vecs[4] = '{lvl: 4'd8, n_ok: 9, mode: MODE_OK,    exp_pulse: 2'b10};
    vecs[5] = '{lvl: 4'd4, n_ok: 0, mode: MODE_WRONG, exp_pulse: 2'b01};

    reset = 1'b1;
    current_state = 2'b00;
    current_level = 4'd0;
    set_sw(4'b0000);
    repeat (3) step();
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lc", int'(level_complete), 0);
    check("rst_go", int'(game_over_signal), 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      int len;
      len = int'(vecs[v].lvl) + 1;
      go_idle();
      run_show(vecs[v].lvl);
      for (int k = 0; k < vecs[v].n_ok; k++) begin
        press(mask_of(exp_buf[k]), (k == len - 1) ? vecs[v].exp_pulse : 2'b00);
      end
      if (vecs[v].mode == MODE_WRONG) begin
        logic [1:0] wrong;
        wrong = exp_buf[vecs[v].n_ok] + 2'd1;
        press(mask_of(wrong), vecs[v].exp_pulse);
      end else if (vecs[v].mode == MODE_CHORD) begin
        press(4'b0101, vecs[v].exp_pulse);
      end
      step();
      check("sb_drained", sb.size(), 0);
    end

    // Abort in CHECK, then replay from the first step.
    go_idle();
    run_show(4'd2);
    press(mask_of(exp_buf[0]), 2'b00);
    current_state = 2'b00;
    step();
    check("abort_busy", int'(busy), 0);
    check("abort_led", int'(led), 0);
    check("abort_pulses", int'({level_complete, game_over_signal}), 0);
    run_show(4'd2);
    press(mask_of(exp_buf[0]), 2'b00);
    press(mask_of(exp_buf[1]), 2'b00);
    press(mask_of(exp_buf[2]), 2'b10);
    step();
    check("abort_sb", sb.size(), 0);

    // Idle player in CHECK.
    go_idle();
    run_show(4'd1);
`ifdef LEVEL_SEQ_TIMEOUT_EN
    sb.push_back('{kind: 2'b01, at: cyc + 20});
    repeat (24) step();
    check("timeout_busy", int'(busy), 0);
`else
    repeat (100) step();
    check("wait_busy", int'(busy), 1);
    current_state = 2'b00;
    step();
    check("wait_abort_busy", int'(busy), 0);
`endif
    check("timeout_sb", sb.size(), 0);

    // Reset in the middle of SHOW_ON.
    go_idle();
    current_level = 4'd1;
    current_state = 2'b01;
    step();
    step();
    check("pre_reset_led", int'(led), int'(mask_of(exp_buf[0])));
    reset = 1'b1;
    current_state = 2'b00;
    step();
    check("mid_reset_led", int'(led), 0);
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_pulses", int'({level_complete, game_over_signal}), 0);
    reset = 1'b0;
    step();
    run_show(4'd0);
    press(mask_of(exp_buf[0]), 2'b10);
    step();

    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
